cp0_timer_random: RTL and testbench
===================================

# cp0_timer_random

Sequential CP0 register slice owning Count, Compare, Random and Wired, plus the MFC0 read path for those registers. It sits beside the CP0 write-mask logic in the CP0 block. It consumes already-masked MTC0 writes and returns read data for the instruction reading CP0. It also generates the timer interrupt and supplies the TLBWR random index.

## Interface
- TLB_ENTRIES, default `TLB_ENTRIES_NUM` (16): TLB size; must be a power of two.
- IDX_W, default $clog2(TLB_ENTRIES): width of Random and Wired.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- we  in  1  MTC0 write strobe.
- waddr  in  5  write register number.
- wsel  in  3  write select field.
- wdata  in  32  write data, already masked by the write mask.
- raddr  in  5  read register number.
- rsel  in  3  read select field.
- rdata  out  32  read data, combinational from current state.
- tlb_random  out  IDX_W  current Random value, used as the TLBWR index.
- timer_int  out  1  sticky timer interrupt request, fed to Cause.IP7.

## Operation
- Writes are decoded only when we=1 and wsel=0. Writes to any other addr/sel are ignored.
- Count (addr 9):
  - A 1-bit phase toggles every cycle.
  - Count increments (mod 2^32) on cycles where phase=1.
  - A write loads wdata and clears phase. The write beats the increment in that cycle.
- Compare (addr 11): a write loads wdata and clears timer_int.
- timer_int (only when CP0_TIMER_INT_EN is defined):
  - Set on the edge after a cycle in which the registered Count equals the registered Compare.
  - Stays set until a Compare write.
  - If a Compare write and a match happen in the same cycle, the write wins and timer_int=0.
- Wired (addr 6):
  - A write loads wdata[IDX_W-1:0].
  - The same write forces Random to TLB_ENTRIES-1 on that edge.
- Random (addr 1, not writable):
  - Each cycle: if Random <= Wired, next = TLB_ENTRIES-1; otherwise next = Random-1.
  - A Wired write overrides this update.
  - Wired=TLB_ENTRIES-1 holds Random at TLB_ENTRIES-1.
- Read mux (rsel=0):
  - addr 9 → Count.
  - addr 11 → Compare.
  - addr 1 → zero-extended Random.
  - addr 6 → zero-extended Wired.
  - Any other addr or sel → 0.
- A read and a write to the same register in the same cycle return the old value. There is no bypass.

## Timing
- Reset values: Count=0, phase=0, Compare=0, Wired=0, Random=TLB_ENTRIES-1, timer_int=0, rdata=0 for rsel=0/raddr=0.
- Asserting rst mid-operation immediately clears all state to the reset values. The first update happens on the first clk edge after rst deasserts.
- Write latency is 1 cycle: the new value is visible on rdata in the cycle after we.
- Read latency is 0 cycles (combinational).
- Count advances once per 2 cycles after reset or a Count write. The first increment lands on the 2nd edge.
- timer_int rises exactly 1 edge after the equality cycle.
- Count wrapping from 0xffffffff goes to 0 with no side effect.

## Configuration
- CP0_TIMER_INT_EN defined: timer_int behaves as specified above.
- CP0_TIMER_INT_EN undefined:
  - timer_int is tied to 0 and the comparator and sticky flop are not built.
  - Compare remains readable and writable.

## Structure
- The shared package `cpu_defs` holds:
  - `uint32_t` and `reg_addr_t`.
  - `TLB_ENTRIES_NUM`.
  - Named CP0 register number constants: RANDOM=1, WIRED=6, COUNT=9, COMPARE=11.
- One sub-module is natural: cp0_random_gen.
  - Holds the Random/Wired state.
  - Inputs: clk, rst, wired write strobe, wired data.
  - Outputs: random, wired.
- Count, Compare, the interrupt logic and the read mux stay in the top module.

## Test plan
- Reset then idle 6 cycles → Count reads 3. Random reads 15,14,…,10 on successive cycles (TLB_ENTRIES=16).
- Write Count=0xffffffff → the read next cycle gives 0xffffffff. Two cycles later the read gives 0x00000000.
- Write Compare=5 after reset → timer_int=1 one edge after Count first equals 5. Write Compare=100 → timer_int=0 next cycle.
- Count equals Compare in the same cycle as a Compare write → timer_int stays 0.
- Write Wired=13 → Random=15 next cycle, then cycles 15,14,13,15,14,13. Write Wired=15 → Random holds at 15.
- Write wsel=1 to addr 9, and read raddr=15 → Count is unchanged and rdata=0. Assert rst mid-count → all reads return reset values at once.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: basic data types, TLB sizing and CP0 register numbers.
package cpu_defs;

    typedef logic [31:0] uint32_t;
    typedef logic [4:0]  reg_addr_t;

    localparam int unsigned TLB_ENTRIES_NUM = 16;

    // CP0 register numbers owned by the timer/random slice
    localparam reg_addr_t RANDOM  = 5'd1;
    localparam reg_addr_t WIRED   = 5'd6;
    localparam reg_addr_t COUNT   = 5'd9;
    localparam reg_addr_t COMPARE = 5'd11;

    // Only select 0 of these registers exists
    function automatic logic is_sel0(input logic [2:0] sel);
        return sel == 3'd0;
    endfunction

endpackage

// File: rtl/cp0_random_gen.sv
// CP0 Random/Wired state: Random counts down from TLB_ENTRIES-1 to Wired,
// then wraps back to the top; a Wired write restarts Random at the top.
module cp0_random_gen
    import cpu_defs::*;
#(
    parameter int unsigned TLB_ENTRIES = TLB_ENTRIES_NUM,
    parameter int unsigned IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wired_we,
    input  logic [IDX_W-1:0] wired_wdata,
    output logic [IDX_W-1:0] random,
    output logic [IDX_W-1:0] wired
);

    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

    logic [IDX_W-1:0] random_q, random_d;
    logic [IDX_W-1:0] wired_q,  wired_d;

    // Next Random/Wired: a Wired write overrides the normal decrement/wrap
    always_comb begin
        wired_d  = wired_q;
        random_d = (random_q <= wired_q) ? RAND_TOP : (random_q - IDX_W'(1));
        if (wired_we) begin
            wired_d  = wired_wdata;
            random_d = RAND_TOP;
        end
    end

    // Random/Wired registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wired_q  <= '0;
            random_q <= RAND_TOP;
        end else begin
            wired_q  <= wired_d;
            random_q <= random_d;
        end
    end

    assign random = random_q;
    assign wired  = wired_q;

endmodule

// File: rtl/cp0_timer_random.sv
// CP0 slice owning Count, Compare, Random and Wired plus their MFC0 read path.
// Optional feature macro: CP0_TIMER_INT_EN builds the Count==Compare
// comparator and the sticky timer interrupt; without it timer_int is 0.
module cp0_timer_random
    import cpu_defs::*;
#(
    parameter int unsigned TLB_ENTRIES = TLB_ENTRIES_NUM,
    parameter int unsigned IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [2:0]       wsel,
    input  logic [31:0]      wdata,
    input  logic [4:0]       raddr,
    input  logic [2:0]       rsel,
    output logic [31:0]      rdata,
    output logic [IDX_W-1:0] tlb_random,
    output logic             timer_int
);

    logic       count_we;
    logic       compare_we;
    logic       wired_we;

    uint32_t    count_q,   count_d;
    logic       phase_q,   phase_d;
    uint32_t    compare_q, compare_d;

    logic [IDX_W-1:0] random_val;
    logic [IDX_W-1:0] wired_val;

    // MTC0 write decode: only select 0 of the owned registers is writable
    always_comb begin
        count_we   = 1'b0;
        compare_we = 1'b0;
        wired_we   = 1'b0;
        if (we && is_sel0(wsel)) begin
            count_we   = (waddr == COUNT);
            compare_we = (waddr == COMPARE);
            wired_we   = (waddr == WIRED);
        end
    end

    // Count advances every other cycle; a write reloads it and restarts the phase
    always_comb begin
        phase_d = ~phase_q;
        count_d = count_q;
        if (phase_q) begin
            count_d = count_q + 32'd1;
        end
        if (count_we) begin
            count_d = wdata;
            phase_d = 1'b0;
        end
    end

    // Compare next value
    always_comb begin
        compare_d = compare_q;
        if (compare_we) begin
            compare_d = wdata;
        end
    end

    // Count, phase and Compare registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            phase_q   <= 1'b0;
            compare_q <= '0;
        end else begin
            count_q   <= count_d;
            phase_q   <= phase_d;
            compare_q <= compare_d;
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic timer_q, timer_d;

    // Sticky interrupt: set by a registered Count/Compare match, cleared by a
    // Compare write, with the write taking priority in the same cycle
    always_comb begin
        timer_d = timer_q;
        if (compare_we) begin
            timer_d = 1'b0;
        end else if (count_q == compare_q) begin
            timer_d = 1'b1;
        end
    end

    // Timer interrupt flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_int = timer_q;
`else
    assign timer_int = 1'b0;
`endif

    cp0_random_gen #(
        .TLB_ENTRIES (TLB_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_random_gen (
        .clk         (clk),
        .rst         (rst),
        .wired_we    (wired_we),
        .wired_wdata (wdata[IDX_W-1:0]),
        .random      (random_val),
        .wired       (wired_val)
    );

    assign tlb_random = random_val;

    // MFC0 read mux from current state; no write bypass
    always_comb begin
        rdata = '0;
        if (is_sel0(rsel)) begin
            case (raddr)
                COUNT:   rdata = count_q;
                COMPARE: rdata = compare_q;
                RANDOM:  rdata[IDX_W-1:0] = random_val;
                WIRED:   rdata[IDX_W-1:0] = wired_val;
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_timer_random.sv
// Self-checking bench for cp0_timer_random (16-entry TLB).
module tb_cp0_timer_random;

    localparam int unsigned TLB = 16;
    localparam int unsigned IW  = 4;

    logic          clk;
    logic          rst;
    logic          we;
    logic [4:0]    waddr;
    logic [2:0]    wsel;
    logic [31:0]   wdata;
    logic [4:0]    raddr;
    logic [2:0]    rsel;
    logic [31:0]   rdata;
    logic [IW-1:0] tlb_random;
    logic          timer_int;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          chk_en  = 0;

    cp0_timer_random #(
        .TLB_ENTRIES (TLB),
        .IDX_W       (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wsel       (wsel),
        .wdata      (wdata),
        .raddr      (raddr),
        .rsel       (rsel),
        .rdata      (rdata),
        .tlb_random (tlb_random),
        .timer_int  (timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: Count is base + half the cycles elapsed since the last
    // reset or Count write; the rest follows the register rules directly.
    logic [31:0] m_base;
    int unsigned m_elapsed;
    logic [31:0] m_compare;
    int unsigned m_wired;
    int unsigned m_random;
    bit          m_timer;

    function automatic logic [31:0] mcount();
        return m_base + 32'(m_elapsed / 2);
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (rsel != 3'd0) return 32'd0;
        case (raddr)
            5'd9:    return mcount();
            5'd11:   return m_compare;
            5'd1:    return 32'(m_random);
            5'd6:    return 32'(m_wired);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_base = 0; m_elapsed = 0; m_compare = 0;
            m_wired = 0; m_random = TLB - 1; m_timer = 0;
        end else begin
            bit w0;
            int unsigned nr;
            w0 = we && (wsel == 3'd0);
`ifdef CP0_TIMER_INT_EN
            if (w0 && waddr == 5'd11) m_timer = 0;
            else if (mcount() == m_compare) m_timer = 1;
`endif
            nr = (m_random <= m_wired) ? TLB - 1 : m_random - 1;
            if (w0 && waddr == 5'd6) begin
                m_wired = wdata % TLB;
                nr = TLB - 1;
            end
            m_random = nr;
            if (w0 && waddr == 5'd9) begin
                m_base = wdata; m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
            if (w0 && waddr == 5'd11) m_compare = wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the clock edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rdata", rdata, exp_rdata());
            check("model_random", 32'(tlb_random), 32'(m_random));
            check("model_timer", 32'(timer_int), 32'(m_timer));
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [2:0] s);
        we = 1'b1; waddr = a; wdata = d; wsel = s;
        next_cyc();
        we = 1'b0; wsel = 3'd0;
    endtask

    task automatic pulse_rst();
        next_cyc();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wsel = '0; wdata = '0;
        raddr = '0; rsel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        check("reset_rdata0", rdata, 32'd0);
        rst = 1'b0;

        // Idle after reset: Random walks down, Count reaches 3 after 6 edges
        raddr = 5'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("random_seq", rdata, 32'(15 - i));
        end
        @(posedge clk); #1;
        raddr = 5'd9;
        @(negedge clk);
        check("count_after6", rdata, 32'd3);

        // Count wrap
        next_cyc();
        wr(5'd9, 32'hffff_ffff, 3'd0);
        @(negedge clk); check("count_wr", rdata, 32'hffff_ffff);
        @(negedge clk); check("count_hold", rdata, 32'hffff_ffff);
        @(negedge clk); check("count_wrap", rdata, 32'h0000_0000);

        // Wired = 13: Random cycles 15,14,13
        next_cyc();
        raddr = 5'd1;
        wr(5'd6, 32'd13, 3'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("wired13_seq", rdata, 32'(15 - (i % 3)));
        end
        // Wired = 15 pins Random at the top
        next_cyc();
        wr(5'd6, 32'd15, 3'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wired15_hold", 32'(tlb_random), 32'd15);
        end

        // Non-zero select write is ignored; unknown reads return 0
        next_cyc();
        raddr = 5'd15;
        wr(5'd9, 32'hdead_beef, 3'd1);
        @(negedge clk); check("read_unmapped", rdata, 32'd0);
        raddr = 5'd9; rsel = 3'd1;
        #1; check("read_sel1", rdata, 32'd0);
        rsel = 3'd0;

        // Reset mid-run clears state immediately
        next_cyc();
        wr(5'd11, 32'd77, 3'd0);
        rst = 1'b1;
        raddr = 5'd9;  #1; check("rst_count", rdata, 32'd0);
        raddr = 5'd1;  #1; check("rst_random", rdata, 32'd15);
        raddr = 5'd6;  #1; check("rst_wired", rdata, 32'd0);
        raddr = 5'd11; #1; check("rst_compare", rdata, 32'd0);
        check("rst_timer", 32'(timer_int), 32'd0);
        next_cyc();
        rst = 1'b0;

`ifdef CP0_TIMER_INT_EN
        // Compare=5: match during the cycle after edge 10, interrupt after edge 11
        pulse_rst();
        wr(5'd11, 32'd5, 3'd0);
        repeat (9) @(posedge clk);
        @(negedge clk); check("timer_before", 32'(timer_int), 32'd0);
        @(negedge clk); check("timer_rise", 32'(timer_int), 32'd1);
        next_cyc();
        wr(5'd11, 32'd100, 3'd0);
        @(negedge clk); check("timer_clear", 32'(timer_int), 32'd0);
        // Compare write coinciding with a match wins
        pulse_rst();
        wr(5'd11, 32'd0, 3'd0);
        @(negedge clk); check("timer_wr_wins", 32'(timer_int), 32'd0);
        @(negedge clk); check("timer_next_match", 32'(timer_int), 32'd1);
`endif

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            next_cyc();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 499) == 0) rst = 1'b1;
            we = ($urandom_range(0, 99) < 30);
            case ($urandom_range(0, 5))
                0: waddr = 5'd1;
                1: waddr = 5'd6;
                2: waddr = 5'd9;
                3: waddr = 5'd11;
                default: waddr = 5'($urandom);
            endcase
            wsel = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
            case ($urandom_range(0, 3))
                0: wdata = mcount() + 32'($urandom_range(0, 3));
                1: wdata = 32'hffff_fffe + 32'($urandom_range(0, 1));
                2: wdata = 32'($urandom_range(0, 15));
                default: wdata = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: raddr = 5'd1;
                1: raddr = 5'd6;
                2: raddr = 5'd9;
                3: raddr = 5'd11;
                default: raddr = 5'($urandom);
            endcase
            rsel = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
        end
        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
